// File: rtl/picomips_pkg.sv
// Shared types and defaults for the picoMIPS fetch front end.
`timescale 1ns/1ps
package picomips_pkg;

  localparam int PSIZE_DEF = 8;
  localparam int ISIZE_DEF = 24;
  localparam int OPC_W     = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [ISIZE_DEF-1:0] word);
    return word[ISIZE_DEF-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Program-memory fetch handshake: req/addr out from the fetch unit, ack/rdata back from memory.
`timescale 1ns/1ps
interface pc_fetch_if #(
  parameter int PSIZE = picomips_pkg::PSIZE_DEF,
  parameter int ISIZE = picomips_pkg::ISIZE_DEF
);
  logic             req;
  logic [PSIZE-1:0] addr;
  logic             ack;
  logic [ISIZE-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_next.sv
// Next-PC selection: absolute > relative > increment > hold, plus a flag for conflicting controls.
`timescale 1ns/1ps
module pc_next #(
  parameter int PSIZE = picomips_pkg::PSIZE_DEF
) (
  input  logic [PSIZE-1:0] pc,
  input  logic             PCincr,
  input  logic             PCrelbranch,
  input  logic             PCabsbranch,
  input  logic [PSIZE-1:0] branch_addr,
  output logic [PSIZE-1:0] next_pc,
  output logic             multi_sel
);

  // Offset is relative to the branching instruction's own address; wraps modulo 2^PSIZE.
  logic signed [PSIZE-1:0] rel_sum;
  assign rel_sum = $signed(pc) + $signed(branch_addr);

  always_comb begin
    next_pc = pc;
    if (PCabsbranch)
      next_pc = branch_addr;
    else if (PCrelbranch)
      next_pc = $unsigned(rel_sum);
    else if (PCincr)
      next_pc = pc + PSIZE'(1);
  end

  assign multi_sel = (PCabsbranch & PCrelbranch) |
                     (PCabsbranch & PCincr) |
                     (PCrelbranch & PCincr);

endmodule

// File: rtl/pc_fetch.sv
// picoMIPS program counter and instruction fetch: fetches the word at pc, holds it until instr_done.
`timescale 1ns/1ps
module pc_fetch
  import picomips_pkg::*;
#(
  parameter int               PSIZE    = PSIZE_DEF,
  parameter int               ISIZE    = ISIZE_DEF,
  parameter logic [PSIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  pc_fetch_if.master       imem,
  output logic [ISIZE-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_done,
  input  logic             PCincr,
  input  logic             PCrelbranch,
  input  logic             PCabsbranch,
  input  logic [PSIZE-1:0] branch_addr,
  output logic [PSIZE-1:0] pc,
  output logic             ctrl_err
);

  fetch_state_t     state;
  logic             req_q;
  logic [PSIZE-1:0] next_pc;
  logic             multi_sel;

  pc_next #(.PSIZE(PSIZE)) u_pc_next (
    .pc          (pc),
    .PCincr      (PCincr),
    .PCrelbranch (PCrelbranch),
    .PCabsbranch (PCabsbranch),
    .branch_addr (branch_addr),
    .next_pc     (next_pc),
    .multi_sel   (multi_sel)
  );

  assign imem.req  = req_q;
  assign imem.addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      req_q       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      ctrl_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_q <= 1'b1;
          state <= S_FETCH;
        end
        S_FETCH: begin
          // ack only counts while our request is actually outstanding
          if (req_q && imem.ack) begin
            instr       <= imem.rdata;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (instr_done) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= S_FETCH;
            if (multi_sel)
              ctrl_err <= 1'b1;
          end
        end
        default: begin
          req_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: drives the memory handshake and PC controls, checks against hand values.
`timescale 1ns/1ps
module tb_pc_fetch;
  import picomips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] instr;
  logic        instr_valid;
  logic        instr_done;
  logic        PCincr, PCrelbranch, PCabsbranch;
  logic [7:0]  branch_addr;
  logic [7:0]  pc;
  logic        ctrl_err;

  int checks = 0;
  int errors = 0;

  pc_fetch_if #(.PSIZE(8), .ISIZE(24)) imem ();

  pc_fetch #(.PSIZE(8), .ISIZE(24), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_done  (instr_done),
    .PCincr      (PCincr),
    .PCrelbranch (PCrelbranch),
    .PCabsbranch (PCabsbranch),
    .branch_addr (branch_addr),
    .pc          (pc),
    .ctrl_err    (ctrl_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; serves one fetch with dly idle request cycles before ack.
  task automatic fetch(input int dly, input logic [23:0] word, input logic [7:0] exp_addr);
    int n = 0;
    while (!imem.req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_up", imem.req, 1);
    check("fetch_addr", imem.addr, exp_addr);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("req_hold", imem.req, 1);
      check("addr_hold", imem.addr, exp_addr);
      check("valid_wait", instr_valid, 0);
    end
    imem.ack   = 1'b1;
    imem.rdata = word;
    @(posedge clk);
    #1;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    check("valid_up", instr_valid, 1);
    check("instr", instr, word);
    check("req_drop", imem.req, 0);
    @(negedge clk);
  endtask

  task automatic retire(input logic inc, input logic rel, input logic abs_b,
                        input logic [7:0] ba, input logic [7:0] exp_pc, input logic exp_err);
    instr_done  = 1'b1;
    PCincr      = inc;
    PCrelbranch = rel;
    PCabsbranch = abs_b;
    branch_addr = ba;
    @(posedge clk);
    #1;
    instr_done  = 1'b0;
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    PCabsbranch = 1'b0;
    branch_addr = '0;
    check("pc", pc, exp_pc);
    check("valid_drop", instr_valid, 0);
    check("ctrl_err", ctrl_err, exp_err);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    instr_done  = 1'b0;
    PCincr      = 1'b0;
    PCrelbranch = 1'b0;
    PCabsbranch = 1'b0;
    branch_addr = '0;
    imem.ack    = 1'b0;
    imem.rdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 8'h00);
    check("rst_req", imem.req, 0);
    check("rst_addr", imem.addr, 8'h00);
    check("rst_instr", instr, 24'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", ctrl_err, 0);
    reset = 1'b0;
    #1;
    check("idle_req", imem.req, 0);
    @(negedge clk);

    // Sequential fetch with ack one cycle after request
    fetch(1, 24'hA00001, 8'h00);
    imem.ack   = 1'b1;
    imem.rdata = 24'hDEAD00;
    @(posedge clk);
    #1;
    imem.ack   = 1'b0;
    imem.rdata = '0;
    check("ack_no_req", instr, 24'hA00001);
    check("valid_kept", instr_valid, 1);
    @(negedge clk);
    retire(1, 0, 0, 8'h00, 8'h01, 0);
    fetch(1, 24'hA10002, 8'h01);
    retire(1, 0, 0, 8'h00, 8'h02, 0);
    fetch(1, 24'hA20003, 8'h02);
    retire(1, 0, 0, 8'h00, 8'h03, 0);
    fetch(1, 24'hA30004, 8'h03);
    retire(1, 0, 0, 8'h00, 8'h04, 0);

    // Relative branches, backward and forward wrap
    fetch(0, 24'h100000, 8'h04);
    retire(0, 0, 1, 8'h10, 8'h10, 0);
    fetch(0, 24'h100010, 8'h10);
    retire(0, 1, 0, 8'hFC, 8'h0C, 0);
    fetch(0, 24'h10000C, 8'h0C);
    retire(0, 0, 1, 8'hFE, 8'hFE, 0);
    fetch(0, 24'h1000FE, 8'hFE);
    retire(0, 1, 0, 8'h03, 8'h01, 0);

    // Increment wrap and halt refetch
    fetch(0, 24'h200001, 8'h01);
    retire(0, 0, 1, 8'hFF, 8'hFF, 0);
    fetch(0, 24'h2000FF, 8'hFF);
    retire(1, 0, 0, 8'h00, 8'h00, 0);
    fetch(0, 24'h200000, 8'h00);
    retire(0, 0, 0, 8'h55, 8'h00, 0);
    fetch(0, 24'h200100, 8'h00);
    retire(1, 0, 0, 8'h00, 8'h01, 0);

    // Slow memory: ack after five waiting cycles
    fetch(5, 24'h3C0001, 8'h01);

    // Conflicting controls: absolute wins, error sticks
    retire(0, 0, 1, 8'h05, 8'h05, 0);
    fetch(0, 24'h400005, 8'h05);
    retire(1, 0, 1, 8'h40, 8'h40, 1);
    fetch(0, 24'h400040, 8'h40);
    retire(1, 0, 0, 8'h00, 8'h41, 1);

    // Asynchronous reset during a pending fetch
    check("pre_rst_req", imem.req, 1);
    #2;
    reset      = 1'b1;
    imem.ack   = 1'b1;
    imem.rdata = 24'hBADBAD;
    #1;
    check("arst_req", imem.req, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc, 8'h00);
    check("arst_err", ctrl_err, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_req", imem.req, 0);
    check("post_rst_valid", instr_valid, 0);
    imem.ack   = 1'b0;
    imem.rdata = '0;
    @(negedge clk);
    fetch(0, 24'h500000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
